mips_mc_control: RTL and testbench

Moore-style main control FSM for the multicycle MIPS datapath. It sequences the architectural and pipeline-boundary registers (PC, IR, register file write port) and the datapath muxes/ALU decode, one instruction state at a time. Memory accesses use a ready handshake so the FSM stalls for slow memory. It sits beside the datapath and consumes the opcode field of the IR.

---
 rtl/mips_mc_control.sv | 233 +++++++++++++++++++++++
 tb/tb_mips_mc_control.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_control.sv
// mips_mc_control
// ----------------
// Moore-style main control FSM for a multicycle MIPS datapath. One state per
// instruction step; the outputs are a combinational decode of the current
// state, and mem_ready qualifies the memory states.
//
// Ports:
//   clk         rising-edge system clock
//   reset       synchronous, active-high; returns to FETCH and forces all
//               write/request enables low while asserted
//   opcode      IR[31:26]
//   mem_ready   memory completes the current read/write this cycle
//   pc_write    unconditional PC load enable
//   branch      conditional PC load (the datapath ANDs it with ALU zero)
//   ir_write    IR load enable
//   reg_write   register file write enable
//   mem_read    memory read request
//   mem_write   memory write request
//   iord        memory address select: 0 = PC, 1 = ALUOut
//   reg_dst     write register select: 0 = rt, 1 = rd
//   mem_to_reg  write data select: 0 = ALUOut, 1 = MDR
//   alu_src_a   ALU A select: 0 = PC, 1 = A
//   alu_src_b   ALU B select: 00 B, 01 4, 10 signext imm, 11 signext imm<<2
//   alu_op      00 add, 01 sub, 10 funct decode
//   pc_src      00 ALU result, 01 ALUOut, 10 jump target
//   instr_done  one-cycle pulse in the last state of each instruction
//   illegal_op  one-cycle pulse in DECODE for an unsupported opcode
//   state       current state code (debug)
//
// Handshake: a memory request (mem_read or mem_write) is held every cycle
// until the cycle in which mem_ready is sampled high; that cycle completes the
// transfer and the FSM advances on the following clock edge.

module mips_mc_control #(
    parameter int USE_MEM_READY = 1,
    parameter int STATE_W       = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               branch,
    output logic               ir_write,
    output logic               reg_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               iord,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_src,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t r_state;
    state_t w_next;
    logic   w_ready;

    // With the handshake disabled every memory access completes in one cycle.
    assign w_ready = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

    assign state = STATE_W'(r_state);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        pc_write   = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        instr_done = 1'b0;
        illegal_op = 1'b0;

        case (r_state)
            S_FETCH: begin
                // PC+4 is computed alongside the read; IR and PC load only
                // in the cycle the instruction word actually arrives.
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = w_ready;
                pc_write  = w_ready;
                if (w_ready) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute the branch target while the opcode is decoded.
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                        w_next     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (opcode == OP_LW) begin
                    w_next = S_MEMRD;
                end else if (opcode == OP_SW) begin
                    w_next = S_MEMWR;
                end else begin
                    // The IR cannot change here; this only guards a corrupt opcode.
                    w_next = S_FETCH;
                end
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (w_ready) begin
                    w_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (w_ready) begin
                    instr_done = 1'b1;
                    w_next     = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
                branch     = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = 2'b10;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            default: begin
                // Codes 12-15 are unreachable; recover with everything idle.
                w_next = S_FETCH;
            end
        endcase

        // Reset overrides the decode so nothing is written or requested
        // while it is held, including in the cycle it is first asserted.
        if (reset) begin
            pc_write   = 1'b0;
            branch     = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            instr_done = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_mc_control.sv
module tb_mips_mc_control;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;

    always #5 clk = ~clk;

    // ---------------- DUT (handshake honoured) ----------------
    logic       pc_write, branch, ir_write, reg_write, mem_read, mem_write;
    logic       iord, reg_dst, mem_to_reg, alu_src_a, instr_done, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;

    mips_mc_control #(.USE_MEM_READY(1), .STATE_W(4)) u_dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .branch(branch), .ir_write(ir_write),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .iord(iord), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .instr_done(instr_done), .illegal_op(illegal_op),
        .state(state)
    );

    // ---------------- DUT (handshake ignored) ----------------
    logic       nr_pc_write, nr_branch, nr_ir_write, nr_reg_write, nr_mem_read, nr_mem_write;
    logic       nr_iord, nr_reg_dst, nr_mem_to_reg, nr_alu_src_a, nr_instr_done, nr_illegal_op;
    logic [1:0] nr_alu_src_b, nr_alu_op, nr_pc_src;
    logic [3:0] nr_state;

    mips_mc_control #(.USE_MEM_READY(0), .STATE_W(4)) u_dut_nr (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(nr_pc_write), .branch(nr_branch), .ir_write(nr_ir_write),
        .reg_write(nr_reg_write), .mem_read(nr_mem_read), .mem_write(nr_mem_write),
        .iord(nr_iord), .reg_dst(nr_reg_dst), .mem_to_reg(nr_mem_to_reg),
        .alu_src_a(nr_alu_src_a), .alu_src_b(nr_alu_src_b), .alu_op(nr_alu_op),
        .pc_src(nr_pc_src), .instr_done(nr_instr_done), .illegal_op(nr_illegal_op),
        .state(nr_state)
    );

    // Observed control word, in the same order the model builds it.
    logic [17:0] obs;
    assign obs = {pc_write, branch, ir_write, reg_write, mem_read, mem_write,
                  iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                  pc_src, instr_done, illegal_op};

    logic [7:0] enables;
    assign enables = {pc_write, branch, ir_write, reg_write, mem_read, mem_write,
                      instr_done, illegal_op};

    // ---------------- scoreboard ----------------
    int tests_run = 0;
    int tests_failed = 0;
    logic [3:0] exp_q[$];
    logic       mr_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected control word for a state, from the state table.
    function automatic logic [17:0] model(input logic [3:0] s, input logic mr, input logic [5:0] op);
        logic pcw, br, irw, rw, mrd, mwr, io, rd, m2r, sa, dn, il;
        logic [1:0] sb, ao, ps;
        {pcw, br, irw, rw, mrd, mwr, io, rd, m2r, sa, dn, il} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (s)
            4'd0:  begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
            4'd1:  begin
                sb = 2'b11;
                if (!(op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010})) begin
                    dn = 1; il = 1;
                end
            end
            4'd2:  begin sa = 1; sb = 2'b10; end
            4'd3:  begin mrd = 1; io = 1; end
            4'd4:  begin rw = 1; m2r = 1; dn = 1; end
            4'd5:  begin mwr = 1; io = 1; dn = mr; end
            4'd6:  begin sa = 1; ao = 2'b10; end
            4'd7:  begin rw = 1; rd = 1; dn = 1; end
            4'd8:  begin sa = 1; ao = 2'b01; ps = 2'b01; br = 1; dn = 1; end
            4'd9:  begin sa = 1; sb = 2'b10; end
            4'd10: begin rw = 1; dn = 1; end
            4'd11: begin pcw = 1; ps = 2'b10; dn = 1; end
            default: ;
        endcase
        return {pcw, br, irw, rw, mrd, mwr, io, rd, m2r, sa, sb, ao, ps, dn, il};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walks the queued states one cycle each, driving the queued mem_ready,
    // checking state and full control word; returns instr_done pulse count.
    task automatic run_seq(input string tag, output int done_cnt);
        logic [3:0] e;
        logic       m;
        done_cnt = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            m = mr_q.pop_front();
            mem_ready = m;
            #1;
            check({tag, "_state"}, 32'(state), 32'(e));
            check({tag, "_ctl"}, 32'(obs), 32'(model(e, m, opcode)));
            if (instr_done) done_cnt++;
            tick();
        end
    endtask

    task automatic push(input logic [3:0] s, input logic m);
        exp_q.push_back(s);
        mr_q.push_back(m);
    endtask

    task automatic run_instr(input string tag, input logic [5:0] op, input int exp_done);
        int d;
        opcode = op;
        run_seq(tag, d);
        #1;
        check({tag, "_end_state"}, 32'(state), 32'd0);
        check({tag, "_done_cnt"}, 32'(d), 32'(exp_done));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int mw_cycles;
        reset = 1'b1;
        mem_ready = 1'b1;
        opcode = 6'b000000;

        tick();
        check("rst1_state", 32'(state), 32'd0);
        check("rst1_en", 32'(enables), 32'd0);
        tick();
        check("rst2_state", 32'(state), 32'd0);
        check("rst2_en", 32'(enables), 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_state", 32'(state), 32'd0);
        check("post_rst_irw_pcw", 32'({ir_write, pc_write}), 32'b11);

        // lw, no stalls: 0,1,2,3,4 then FETCH
        push(0, 1); push(1, 1); push(2, 1); push(3, 1); push(4, 1);
        run_instr("lw", 6'b100011, 1);

        // sw with three stalled MEMWR cycles
        push(0, 1); push(1, 1); push(2, 1);
        push(5, 0); push(5, 0); push(5, 0); push(5, 1);
        mw_cycles = 0;
        opcode = 6'b101011;
        begin
            int d;
            logic [3:0] e;
            logic m;
            d = 0;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                m = mr_q.pop_front();
                mem_ready = m;
                #1;
                check("sw_state", 32'(state), 32'(e));
                check("sw_ctl", 32'(obs), 32'(model(e, m, opcode)));
                if (mem_write && iord) mw_cycles++;
                if (instr_done) d++;
                tick();
            end
            #1;
            check("sw_end_state", 32'(state), 32'd0);
            check("sw_done_cnt", 32'(d), 32'd1);
            check("sw_mw_cycles", 32'(mw_cycles), 32'd4);
        end

        // R-type, beq, j back to back
        push(0, 1); push(1, 1); push(6, 1); push(7, 1);
        run_instr("rtype", 6'b000000, 1);
        push(0, 1); push(1, 1); push(8, 1);
        run_instr("beq", 6'b000100, 1);
        push(0, 1); push(1, 1); push(11, 1);
        run_instr("j", 6'b000010, 1);

        // addi
        push(0, 1); push(1, 1); push(9, 1); push(10, 1);
        run_instr("addi", 6'b001000, 1);

        // FETCH stall then illegal opcode
        push(0, 0); push(0, 0); push(0, 1); push(1, 1);
        run_instr("illegal", 6'b111111, 1);

        // reset asserted during a stalled MEMRD
        opcode = 6'b100011;
        push(0, 1); push(1, 1); push(2, 1);
        begin
            int d;
            run_seq("lw_abort", d);
        end
        mem_ready = 1'b0;
        #1;
        check("abort_memrd_state", 32'(state), 32'd3);
        check("abort_memrd_rd", 32'(mem_read), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_rst_rd", 32'(mem_read), 32'd0);
        check("abort_rst_en", 32'(enables), 32'd0);
        tick();
        check("abort_next_state", 32'(state), 32'd0);
        check("abort_next_en", 32'(enables), 32'd0);

        // handshake ignored: FETCH advances with mem_ready low
        opcode = 6'b000000;
        mem_ready = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check("nr_fetch_state", 32'(nr_state), 32'd0);
        check("nr_fetch_irw", 32'(nr_ir_write), 32'd1);
        check("main_fetch_irw", 32'(ir_write), 32'd0);
        tick();
        check("nr_s1", 32'(nr_state), 32'd1);
        check("main_stall", 32'(state), 32'd0);
        tick();
        check("nr_s6", 32'(nr_state), 32'd6);
        check("nr_exec_aluop", 32'(nr_alu_op), 32'b10);
        tick();
        check("nr_s7", 32'(nr_state), 32'd7);
        check("nr_aluwb_done", 32'({nr_reg_write, nr_reg_dst, nr_instr_done}), 32'b111);
        tick();
        check("nr_s0", 32'(nr_state), 32'd0);
        check("main_still_stalled", 32'(state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
